// File: rtl/rename_maptable_if.sv
// Rename-stage bundle: dispatch, freelist grant, branch resolution and rename/recovery results.
// master drives the requests (upstream pipeline), slave is the map table.
interface rename_maptable_if #(
    parameter int WAYS   = 2,
    parameter int N_ARCH = 32,
    parameter int N_PHYS = 64,
    parameter int N_CKPT = 4
);
    localparam int PR_W = $clog2(N_PHYS);
    localparam int CK_W = $clog2(N_CKPT);

    logic [WAYS-1:0]        disp_valid;
    logic [WAYS*5-1:0]      disp_dest;
    logic [WAYS*5-1:0]      disp_src1;
    logic [WAYS*5-1:0]      disp_src2;
    logic [WAYS-1:0]        disp_is_br;
    logic [WAYS-1:0]        fl_valid;
    logic [WAYS*PR_W-1:0]   fl_t_idx;
    logic                   br_resolve;
    logic                   br_mispredict;
    logic [WAYS*PR_W-1:0]   src1_pr;
    logic [WAYS*PR_W-1:0]   src2_pr;
    logic [WAYS*PR_W-1:0]   told_idx;
    logic [CK_W-1:0]        br_ckpt_id;
    logic                   ckpt_full;
    logic                   recover_en;
    logic [N_ARCH*PR_W-1:0] recover_map;

    modport master (
        output disp_valid, disp_dest, disp_src1, disp_src2, disp_is_br,
               fl_valid, fl_t_idx, br_resolve, br_mispredict,
        input  src1_pr, src2_pr, told_idx, br_ckpt_id, ckpt_full,
               recover_en, recover_map
    );

    modport slave (
        input  disp_valid, disp_dest, disp_src1, disp_src2, disp_is_br,
               fl_valid, fl_t_idx, br_resolve, br_mispredict,
        output src1_pr, src2_pr, told_idx, br_ckpt_id, ckpt_full,
               recover_en, recover_map
    );
endinterface

// File: rtl/rename_maptable.sv
// Speculative register alias table for the multi-way rename stage, with a circular FIFO
// of branch checkpoints used to restore the map on a mispredict.
module rename_maptable #(
    parameter int WAYS   = 2,
    parameter int N_ARCH = 32,
    parameter int N_PHYS = 64,
    parameter int N_CKPT = 4
) (
    input  logic              clock,
    input  logic              reset,
    rename_maptable_if.slave  bus
);
    localparam int PR_W = $clog2(N_PHYS);
    localparam int CK_W = $clog2(N_CKPT);

    typedef logic [PR_W-1:0] pr_t;

    pr_t             map_q  [N_ARCH];
    pr_t             ckpt_q [N_CKPT][N_ARCH];
    logic [CK_W-1:0] head_q;
    logic [CK_W-1:0] tail_q;
    logic [CK_W:0]   count_q;

    // stage[w] is the map as seen by way w: committed map plus updates of ways 0..w-1
    pr_t             stage [WAYS+1][N_ARCH];
    logic [WAYS-1:0] upd;
    logic            br_req;
    int unsigned     br_way;
    logic            mispredict;
    logic            resolve_ok;
    logic            br_take;

    always_comb begin
        stage[0] = map_q;
        upd      = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            upd[w]       = bus.disp_valid[w] & bus.fl_valid[w] & (bus.disp_dest[w*5 +: 5] != 5'd0);
            stage[w+1]   = stage[w];
            if (upd[w])
                stage[w+1][bus.disp_dest[w*5 +: 5]] = bus.fl_t_idx[w*PR_W +: PR_W];
        end
    end

    always_comb begin
        br_req = 1'b0;
        br_way = 0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!br_req && bus.disp_valid[w] && bus.disp_is_br[w]) begin
                br_req = 1'b1;
                br_way = w;
            end
        end
    end

    assign mispredict    = bus.br_resolve & bus.br_mispredict;
    assign resolve_ok    = bus.br_resolve & ~bus.br_mispredict & (count_q != '0);
    assign bus.ckpt_full = (count_q == (CK_W+1)'(N_CKPT));
    assign br_take       = br_req & ~bus.ckpt_full & ~mispredict;
    assign bus.br_ckpt_id = tail_q;
    assign bus.recover_en = mispredict;

    always_comb begin
        bus.src1_pr  = '0;
        bus.src2_pr  = '0;
        bus.told_idx = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (bus.disp_src1[w*5 +: 5] != 5'd0)
                bus.src1_pr[w*PR_W +: PR_W] = stage[w][bus.disp_src1[w*5 +: 5]];
            if (bus.disp_src2[w*5 +: 5] != 5'd0)
                bus.src2_pr[w*PR_W +: PR_W] = stage[w][bus.disp_src2[w*5 +: 5]];
            if (bus.disp_dest[w*5 +: 5] != 5'd0)
                bus.told_idx[w*PR_W +: PR_W] = stage[w][bus.disp_dest[w*5 +: 5]];
        end
    end

    always_comb begin
        bus.recover_map = '0;
        for (int unsigned a = 0; a < N_ARCH; a++) begin
            if (mispredict)
                bus.recover_map[a*PR_W +: PR_W] = ckpt_q[head_q][a];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned a = 0; a < N_ARCH; a++)
                map_q[a] <= PR_W'(a);
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (mispredict) begin
            map_q   <= ckpt_q[head_q];
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            map_q   <= stage[WAYS];
            tail_q  <= tail_q + CK_W'(br_take);
            head_q  <= head_q + CK_W'(resolve_ok);
            count_q <= count_q + (CK_W+1)'(br_take) - (CK_W+1)'(resolve_ok);
        end
    end

    // Checkpoint contents need no reset; liveness is tracked by head/tail/count
    always_ff @(posedge clock) begin
        if (!reset && br_take)
            ckpt_q[tail_q] <= stage[br_way+1];
    end
endmodule
